// File: rtl/mfcc_feature_stage.sv
// MFCC feature stage: keeps a window of DCT cepstral coefficients per frame,
// optionally appends frame-to-frame deltas, with a registered output slot.
module mfcc_feature_stage #(
    parameter int DATA_WIDTH   = 16,
    parameter int N_COEFS      = 32,
    parameter int FIRST_COEF   = 0,
    parameter int NUM_FEATURES = 13,
    parameter int DELTA_SHIFT  = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  delta_en_in,
    input  logic [DATA_WIDTH-1:0] dct_data_in,
    input  logic                  dct_valid_in,
    input  logic                  dct_last_in,
    output logic                  dct_ready_out,
    output logic [DATA_WIDTH-1:0] feature_data_out,
    output logic                  feature_valid_out,
    output logic                  feature_last_out,
    input  logic                  feature_ready_in,
    output logic                  len_err_out
);

    localparam int IDX_W = $clog2(N_COEFS);
    localparam int K_W   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_COEFS - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(FIRST_COEF);
    localparam logic [IDX_W-1:0] IDX_WEND  = IDX_W'(FIRST_COEF + NUM_FEATURES - 1);
    localparam logic [IDX_W:0]   NUM_EXT   = (IDX_W + 1)'(NUM_FEATURES);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_FEATURES - 1);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_STATIC = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_DELTA  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, off;
    logic [K_W-1:0]   k_q, k_d, off_k;
    logic             mode_q, mode_eff, prev_valid_q, ovf_q, run_q;
    logic             in_win, win_end, out_free, acc;
    logic             ld_static, ld_delta, st_last, commit;

    logic signed [DATA_WIDTH-1:0] cur_q  [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] prev_q [NUM_FEATURES];
    logic signed [DATA_WIDTH:0]   diff, diff_sh;
    logic signed [DATA_WIDTH-1:0] delta_val;

    // Offset wraps high below the window, so one compare covers both ends
    assign off      = idx_q - IDX_FIRST;
    assign off_k    = off[K_W-1:0];
    assign in_win   = {1'b0, off} < NUM_EXT;
    assign win_end  = idx_q == IDX_WEND;
    assign out_free = !feature_valid_out || feature_ready_in;
    assign mode_eff = (idx_q == '0) ? delta_en_in : mode_q;
    assign acc      = dct_valid_in && dct_ready_out;

    // Input handshake: stall only in-window beats on a full slot, and all of DELTA
    always_comb begin
        dct_ready_out = 1'b0;
        if (run_q) begin
            unique case (state_q)
                ST_STATIC: dct_ready_out = in_win ? out_free : 1'b1;
                ST_DRAIN:  dct_ready_out = 1'b1;
                default:   dct_ready_out = 1'b0;
            endcase
        end
    end

    // Saturating delta of the current feature against the previous frame
    always_comb begin
        diff = {cur_q[k_q][DATA_WIDTH-1], cur_q[k_q]}
             - {prev_q[k_q][DATA_WIDTH-1], prev_q[k_q]};
        diff_sh = diff >>> DELTA_SHIFT;
        if (diff_sh[DATA_WIDTH] != diff_sh[DATA_WIDTH-1]) begin
            delta_val = diff_sh[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            delta_val = diff_sh[DATA_WIDTH-1:0];
        end
        if (!prev_valid_q) begin
            delta_val = '0;
        end
    end

    // Frame sequencing; the finish step folds into the last accepting cycle
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ld_static = 1'b0;
        ld_delta  = 1'b0;
        st_last   = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            ST_STATIC: begin
                if (acc && in_win) begin
                    ld_static = 1'b1;
                    if (win_end) begin
                        st_last = !mode_eff;
                        if (!dct_last_in) begin
                            state_d = ST_DRAIN;
                        end else if (mode_eff) begin
                            state_d = ST_DELTA;
                            k_d     = '0;
                        end else begin
                            commit = 1'b1;
                        end
                    end else if (dct_last_in) begin
                        st_last = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (acc && dct_last_in) begin
                    if (mode_q) begin
                        state_d = ST_DELTA;
                        k_d     = '0;
                    end else begin
                        state_d = ST_STATIC;
                        commit  = 1'b1;
                    end
                end
            end
            ST_DELTA: begin
                if (out_free) begin
                    ld_delta = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = ST_STATIC;
                        commit  = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_STATIC;
        endcase
    end

    // Control state, beat index, mode latch and length-error pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_q        <= 1'b0;
            state_q      <= ST_STATIC;
            idx_q        <= '0;
            k_q          <= '0;
            mode_q       <= 1'b0;
            ovf_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            len_err_out  <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            state_q     <= state_d;
            k_q         <= k_d;
            len_err_out <= acc && dct_last_in && (idx_q != IDX_MAX || ovf_q);
            if (acc) begin
                if (idx_q == '0 && !ovf_q) begin
                    mode_q <= delta_en_in;
                end
                if (dct_last_in) begin
                    idx_q <= '0;
                    ovf_q <= 1'b0;
                end else if (idx_q == IDX_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (commit) begin
                prev_valid_q <= 1'b1;
            end
        end
    end

    // Current/previous frame feature stores; commit captures a same-cycle write
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                cur_q[i]  <= '0;
                prev_q[i] <= '0;
            end
        end else begin
            if (ld_static) begin
                cur_q[off_k] <= dct_data_in;
            end
            if (commit) begin
                for (int i = 0; i < NUM_FEATURES; i++) begin
                    prev_q[i] <= (ld_static && off_k == K_W'(i)) ? dct_data_in : cur_q[i];
                end
            end
        end
    end

    // Single-entry output slot; load and drain may overlap in one cycle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            feature_valid_out <= 1'b0;
            feature_last_out  <= 1'b0;
            feature_data_out  <= '0;
        end else if (ld_static) begin
            feature_valid_out <= 1'b1;
            feature_last_out  <= st_last;
            feature_data_out  <= dct_data_in;
        end else if (ld_delta) begin
            feature_valid_out <= 1'b1;
            feature_last_out  <= k_q == K_LAST;
            feature_data_out  <= delta_val;
        end else if (feature_ready_in) begin
            feature_valid_out <= 1'b0;
            feature_last_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mfcc_feature_stage.sv
// Directed bench for mfcc_feature_stage: default-window instance (a)
// and FIRST_COEF=1/NUM_FEATURES=12 instance (b) share the stimulus.
module tb_mfcc_feature_stage;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        den    = 1'b0;
    logic        vld    = 1'b0;
    logic        lst    = 1'b0;
    logic        fr     = 1'b1;
    logic [15:0] dat    = '0;
    logic        sel    = 1'b0;
    logic        bp_on  = 1'b0;

    logic        a_rdy, a_fv, a_fl, a_le;
    logic [15:0] a_fd;
    logic        b_rdy, b_fv, b_fl, b_le;
    logic [15:0] b_fd;

    logic        rdy, fv, fl, le;
    logic [15:0] fd;

    assign rdy = sel ? b_rdy : a_rdy;
    assign fv  = sel ? b_fv  : a_fv;
    assign fl  = sel ? b_fl  : a_fl;
    assign le  = sel ? b_le  : a_le;
    assign fd  = sel ? b_fd  : a_fd;

    mfcc_feature_stage u_a (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n),
        .delta_en_in       (den),
        .dct_data_in       (dat),
        .dct_valid_in      (vld),
        .dct_last_in       (lst),
        .dct_ready_out     (a_rdy),
        .feature_data_out  (a_fd),
        .feature_valid_out (a_fv),
        .feature_last_out  (a_fl),
        .feature_ready_in  (fr),
        .len_err_out       (a_le)
    );

    mfcc_feature_stage #(
        .FIRST_COEF   (1),
        .NUM_FEATURES (12)
    ) u_b (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n),
        .delta_en_in       (den),
        .dct_data_in       (dat),
        .dct_valid_in      (vld),
        .dct_last_in       (lst),
        .dct_ready_out     (b_rdy),
        .feature_data_out  (b_fd),
        .feature_valid_out (b_fv),
        .feature_last_out  (b_fl),
        .feature_ready_in  (fr),
        .len_err_out       (b_le)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_pass = 0;
    int lerr_cnt = 0;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    logic        stall_p = 1'b0;
    logic [15:0] stall_d = '0;
    logic        stall_l = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: transfers, len_err cycles, stall stability
    always @(negedge clk_in) begin
        if (fv && fr) begin
            got_q.push_back({fl, fd});
        end
        if (le) begin
            lerr_cnt++;
        end
        if (bp_on && stall_p) begin
            chk("stall_valid", int'(fv), 1);
            chk("stall_data", int'(fd), int'(stall_d));
            chk("stall_last", int'(fl), int'(stall_l));
        end
        stall_p = fv && !fr;
        stall_d = fd;
        stall_l = fl;
    end

    // Downstream backpressure pattern 1-0-1-0
    always @(posedge clk_in) begin
        #1;
        if (bp_on) begin
            fr = ~fr;
        end
    end

    task automatic push_exp(input int v, input int l);
        exp_q.push_back({l[0], v[15:0]});
    endtask

    task automatic do_reset();
        vld   = 1'b0;
        lst   = 1'b0;
        den   = 1'b0;
        fr    = 1'b1;
        bp_on = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        got_q.delete();
        exp_q.delete();
        lerr_cnt = 0;
        stall_p  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int mul, input logic de,
                              input bit use0, input logic [15:0] d0,
                              input bit rchk);
        for (int i = 0; i < n; i++) begin
            int t;
            logic [15:0] v;
            v = 16'(i * mul);
            if (i == 0 && use0) v = d0;
            dat = v;
            vld = 1'b1;
            lst = (i == n - 1);
            den = de;
            t = 0;
            @(negedge clk_in);
            if (rchk) chk("dct_ready", int'(rdy), (i < 13) ? int'(!fv || fr) : 1);
            while (!rdy && t < 200) begin
                @(negedge clk_in);
                t++;
                if (rchk) chk("dct_ready", int'(rdy), (i < 13) ? int'(!fv || fr) : 1);
            end
            if (!rdy) chk("accept_timeout", 0, 1);
            @(posedge clk_in);
            #1;
        end
        vld = 1'b0;
        lst = 1'b0;
    endtask

    task automatic compare_out(input string tag, input bit settle);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            @(posedge clk_in);
            #2;
            t++;
        end
        if (settle) begin
            repeat (6) @(posedge clk_in);
            #2;
        end
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_data"}, int'(got_q[i][15:0]), int'(exp_q[i][15:0]));
            chk({tag, "_last"}, int'(got_q[i][16]), int'(exp_q[i][16]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", int'(a_fv), 0);
        chk("rst_last", int'(a_fl), 0);
        chk("rst_data", int'(a_fd), 0);
        chk("rst_lerr", int'(a_le), 0);
        chk("rst_ready", int'(a_rdy), 0);

        // 1: plain statics, default window
        sel = 1'b0;
        do_reset();
        send_frame(32, 1, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 13; i++) push_exp(i, int'(i == 12));
        compare_out("t1", 1'b1);
        chk("t1_lerr", lerr_cnt, 0);

        // 2: shifted window with deltas
        sel = 1'b1;
        do_reset();
        send_frame(32, 1, 1'b1, 1'b0, 16'h0, 1'b0);
        send_frame(32, 2, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 12; i++) push_exp(i, 0);
        for (int i = 1; i <= 12; i++) push_exp(0, int'(i == 12));
        for (int i = 1; i <= 12; i++) push_exp(2 * i, 0);
        for (int i = 1; i <= 12; i++) push_exp(i, int'(i == 12));
        compare_out("t2", 1'b1);
        chk("t2_lerr", lerr_cnt, 0);

        // 3: delta saturation both directions
        sel = 1'b0;
        do_reset();
        send_frame(32, 0, 1'b1, 1'b1, 16'h8000, 1'b0);
        send_frame(32, 0, 1'b1, 1'b1, 16'h7fff, 1'b0);
        send_frame(32, 0, 1'b1, 1'b1, 16'h8000, 1'b0);
        push_exp(32'h8000, 0);
        for (int i = 1; i < 13; i++) push_exp(0, 0);
        for (int i = 0; i < 13; i++) push_exp(0, int'(i == 12));
        push_exp(32'h7fff, 0);
        for (int i = 1; i < 13; i++) push_exp(0, 0);
        push_exp(32'h7fff, 0);
        for (int i = 1; i < 13; i++) push_exp(0, int'(i == 12));
        push_exp(32'h8000, 0);
        for (int i = 1; i < 13; i++) push_exp(0, 0);
        push_exp(32'h8000, 0);
        for (int i = 1; i < 13; i++) push_exp(0, int'(i == 12));
        compare_out("t3", 1'b1);
        chk("t3_lerr", lerr_cnt, 0);

        // 4: backpressure on the plain frame
        sel = 1'b0;
        do_reset();
        bp_on = 1'b1;
        send_frame(32, 1, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 13; i++) push_exp(i, int'(i == 12));
        compare_out("t4", 1'b1);
        bp_on = 1'b0;
        fr = 1'b1;
        chk("t4_lerr", lerr_cnt, 0);

        // 5: short frame then a normal one
        sel = 1'b0;
        do_reset();
        send_frame(6, 1, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 6; i++) push_exp(i, int'(i == 5));
        compare_out("t5a", 1'b1);
        chk("t5a_lerr", lerr_cnt, 1);
        lerr_cnt = 0;
        send_frame(32, 3, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 13; i++) push_exp(3 * i, 0);
        for (int i = 0; i < 13; i++) push_exp(0, int'(i == 12));
        compare_out("t5b", 1'b1);
        chk("t5b_lerr", lerr_cnt, 0);

        // 6: reset in the middle of the delta burst
        sel = 1'b1;
        do_reset();
        send_frame(32, 1, 1'b1, 1'b0, 16'h0, 1'b0);
        send_frame(32, 2, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 12; i++) push_exp(i, 0);
        for (int i = 1; i <= 12; i++) push_exp(0, int'(i == 12));
        for (int i = 1; i <= 12; i++) push_exp(2 * i, 0);
        for (int i = 1; i <= 4; i++) push_exp(i, 0);
        compare_out("t6a", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(b_fv), 0);
        chk("t6_rst_last", int'(b_fl), 0);
        chk("t6_rst_data", int'(b_fd), 0);
        chk("t6_rst_lerr", int'(b_le), 0);
        chk("t6_rst_ready", int'(b_rdy), 0);
        do_reset();
        send_frame(32, 5, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 12; i++) push_exp(5 * i, 0);
        for (int i = 1; i <= 12; i++) push_exp(0, int'(i == 12));
        compare_out("t6b", 1'b1);
        chk("t6b_lerr", lerr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mfcc_feature_stage.md
Name: mfcc_feature_stage

Overview:
- Parametrised successor to the feature-extractor output truncation stage. Sits between the DCT stream and the feature consumer.
- Selects a configurable window of cepstral coefficients from each DCT frame and discards the rest.
- Optionally appends per-coefficient delta features, computed as the current frame minus the previous frame.
- Honours downstream backpressure via a registered output stage, and flags malformed frame lengths.

Parameters:
- DATA_WIDTH, 16, width of signed two's-complement coefficients in and out.
- N_COEFS, 32, DCT coefficients per well-formed frame.
- FIRST_COEF, 0, index of the first kept coefficient (set to 1 to drop C0).
- NUM_FEATURES, 13, number of kept coefficients. FIRST_COEF+NUM_FEATURES <= N_COEFS.
- DELTA_SHIFT, 0, arithmetic right shift applied to deltas before saturation.

Ports:
- clk_in, input, 1, clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- delta_en_in, input, 1, 1 = emit NUM_FEATURES statics then NUM_FEATURES deltas per frame; sampled at frame start.
- dct_data_in, input, DATA_WIDTH, DCT coefficient.
- dct_valid_in, input, 1, input beat valid.
- dct_last_in, input, 1, final coefficient of frame.
- dct_ready_out, output, 1, input beat accepted when valid&&ready.
- feature_data_out, output, DATA_WIDTH, feature value.
- feature_valid_out, output, 1, output beat valid.
- feature_last_out, output, 1, final feature of frame.
- feature_ready_in, input, 1, downstream ready.
- len_err_out, output, 1, one-cycle pulse: frame's last beat not at index N_COEFS-1.

Behaviour:
- Reset (async, rst_n_in=0) clears:
  - all outputs: feature_valid_out=0, feature_last_out=0, feature_data_out=0, len_err_out=0, dct_ready_out=0;
  - idx counter, state=STATIC, prev_valid=0, cur/prev arrays.
  - Reset mid-frame discards the partial frame entirely.
- idx counts accepted input beats per frame, 0..N_COEFS-1, saturating at N_COEFS-1. It returns to 0 after an accepted dct_last_in.
- Window: FIRST_COEF <= idx < FIRST_COEF+NUM_FEATURES.
- delta_en_in is latched into mode on the accepted beat with idx==0. Changes mid-frame are ignored.
- Output register is single-entry. It is free when !feature_valid_out || feature_ready_in. feature_valid_out/data/last hold stable while stalled.
- STATIC state:
  - In-window beat: dct_ready_out = output register free. On accept, the data is loaded into the output register (latency 1 cycle) and stored into cur[idx-FIRST_COEF].
  - Out-of-window beat: dct_ready_out=1, discarded.
  - After the final in-window beat is accepted:
    - if it also carries dct_last → FINISH;
    - else → DRAIN.
- DRAIN: dct_ready_out=1, all beats discarded. On accepted dct_last → FINISH.
- FINISH (internal, zero output beats), decided in the same cycle as the last accept:
  - mode=1 → DELTA with k=0;
  - mode=0 → STATIC, prev<=cur, prev_valid<=1.
- DELTA state:
  - dct_ready_out=0.
  - Each free output slot loads d_k, then k increments.
  - d_k = sat_DATA_WIDTH((cur[k]-prev[k]) >>> DELTA_SHIFT), computed at DATA_WIDTH+1 bits. sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If prev_valid=0, d_k=0.
  - After k=NUM_FEATURES-1 is loaded: prev<=cur, prev_valid<=1, state → STATIC.
- feature_last_out=1 on exactly one beat per frame:
  - mode=0: the final in-window static;
  - mode=1: the delta with k=NUM_FEATURES-1.
- Short frame, dct_last accepted inside the window before the window completes:
  - that static is emitted with feature_last_out=1;
  - no deltas; prev/prev_valid unchanged; len_err pulse; → STATIC.
- Short frame, dct_last accepted before the window is reached:
  - no output for that frame; len_err pulse.
- Long frame, no dct_last at idx N_COEFS-1: continue discarding until dct_last. len_err pulses on that accept; features are still valid.
- Any dct_last at idx != N_COEFS-1 → len_err_out=1 on the following cycle for one cycle.
- Simultaneous output-register drain and load in one cycle is allowed: full throughput, one beat per cycle.

Test Plan:
1. Defaults, delta_en=0, frame of 32 beats with data=idx, feature_ready_in=1 → 13 outputs 0..12, last on value 12, no len_err, dct_ready_out=1 throughout.
2. FIRST_COEF=1, NUM_FEATURES=12, delta_en=1, frame A data=idx then frame B data=2*idx:
   - frame A → statics 1..12, deltas all 0 (prev_valid=0);
   - frame B → statics 2..24 step 2, deltas 1..12, last only on delta 12.
3. Saturation, DELTA_SHIFT=0: prev[0]=-32768 then cur[0]=32767 → d_0=32767. Reversed → d_0=-32768.
4. Backpressure: feature_ready_in toggles 1-0-1-0 during scenario 1 → identical output sequence, data stable while stalled, dct_ready_out=0 on in-window beats only when the register is full.
5. Short frame, dct_last at idx 5 with delta_en=1:
   - 6 statics, last on the 6th, no deltas, len_err one pulse;
   - next normal frame's deltas are still 0 (prev_valid=0).
6. Assert rst_n_in mid-DELTA after 4 deltas → outputs clear immediately. Next frame behaves as first after reset (deltas 0).
